// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state enum, opcodes, mux encodings
// and the per-state registered output table. RV_JAL_EN gates the JAL state at decode.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } ctrl_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       pc_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_out_t;

    // Outputs that depend only on the state; mem_ready/zero qualified strobes are added in the top.
    function automatic ctrl_out_t state_outputs(input ctrl_state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.mem_req    = 1'b1;
                o.alu_src_a  = SRCA_PC;
                o.alu_src_b  = SRCB_FOUR;
                o.alu_op     = ALUOP_ADD;
                o.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                o.alu_src_a = SRCA_OLDPC;
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                o.mem_req = 1'b1;
                o.adr_src = 1'b1;
            end
            S_MEMWB: begin
                o.result_src = RES_MEMDATA;
                o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o.mem_req   = 1'b1;
                o.mem_write = 1'b1;
                o.adr_src   = 1'b1;
            end
            S_EXECR: begin
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_RS2;
                o.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                o.alu_src_a = SRCA_RS1;
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o.result_src = RES_ALUOUT;
                o.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                o.alu_src_a  = SRCA_RS1;
                o.alu_src_b  = SRCB_RS2;
                o.alu_op     = ALUOP_SUB;
                o.result_src = RES_ALUOUT;
            end
            S_JAL: begin
                o.alu_src_a  = SRCA_OLDPC;
                o.alu_src_b  = SRCB_FOUR;
                o.alu_op     = ALUOP_ADD;
                o.result_src = RES_ALUOUT;
                o.pc_write   = 1'b1;
            end
            S_TRAP: o.illegal = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational immediate-format select from the held opcode.
// J format for jal is only produced when RV_JAL_EN is defined.
module imm_src_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_LOAD, OP_ITYPE: imm_src = IMM_I;
            OP_STORE:          imm_src = IMM_S;
            OP_BRANCH:         imm_src = IMM_B;
`ifdef RV_JAL_EN
            OP_JAL:            imm_src = IMM_J;
`endif
            default:           imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with registered per-state outputs and a sticky trap.
// Define RV_JAL_EN to decode jal into the JAL state instead of trapping.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic       illegal_op
);

    ctrl_state_t r_state;
    ctrl_out_t   r_out;
    ctrl_state_t w_next;
    logic        w_fetch_done;
    logic        w_branch_taken;

    function automatic ctrl_state_t decode_next(input logic [6:0] o, input logic [2:0] f3);
        ctrl_state_t n;
        case (o)
            OP_LOAD, OP_STORE: n = S_MEMADR;
            OP_RTYPE:          n = S_EXECR;
            OP_ITYPE:          n = S_EXECI;
            OP_BRANCH:         n = (f3 == 3'b000 || f3 == 3'b001) ? S_BRANCH : S_TRAP;
`ifdef RV_JAL_EN
            OP_JAL:            n = S_JAL;
`endif
            default:           n = S_TRAP;
        endcase
        return n;
    endfunction

    function automatic ctrl_state_t next_state(input ctrl_state_t s, input logic [6:0] o,
                                               input logic [2:0] f3, input logic rdy);
        ctrl_state_t n;
        case (s)
            S_IDLE:     n = S_FETCH;
            S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
            S_DECODE:   n = decode_next(o, f3);
            S_MEMADR:   n = (o == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  n = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    n = S_FETCH;
            S_MEMWRITE: n = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    n = S_ALUWB;
            S_EXECI:    n = S_ALUWB;
            S_ALUWB:    n = S_FETCH;
            S_BRANCH:   n = S_FETCH;
            S_JAL:      n = S_ALUWB;
            S_TRAP:     n = S_TRAP;
            default:    n = S_IDLE;
        endcase
        return n;
    endfunction

    assign w_next = next_state(r_state, op, funct3, mem_ready);

    // Outputs are loaded together with the state so they change exactly on state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= state_outputs(w_next);
        end
    end

    // Strobes that must react within the cycle to mem_ready or the ALU flag.
    assign w_fetch_done   = (r_state == S_FETCH) && mem_ready;
    assign w_branch_taken = (r_state == S_BRANCH) && (zero ^ funct3[0]);

    assign mem_req    = r_out.mem_req;
    assign MemWrite   = r_out.mem_write;
    assign AdrSrc     = r_out.adr_src;
    assign IRWrite    = w_fetch_done;
    assign PCWrite    = r_out.pc_write | w_fetch_done | w_branch_taken;
    assign RegWrite   = r_out.reg_write;
    assign ResultSrc  = r_out.result_src;
    assign ALUSrcA    = r_out.alu_src_a;
    assign ALUSrcB    = r_out.alu_src_b;
    assign ALUOp      = r_out.alu_op;
    assign illegal_op = r_out.illegal;

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (ImmSrc)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into its phase list from the opcode class,
// and every cycle's outputs are compared against the per-phase output table.
module tb_multicycle_controller;

`ifdef RV_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MEMADR = 3, PH_MEMREAD = 4,
                   PH_MEMWB = 5, PH_MEMWRITE = 6, PH_EXECR = 7, PH_EXECI = 8, PH_ALUWB = 9,
                   PH_BRANCH = 10, PH_JAL = 11, PH_TRAP = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0010011;
    logic [2:0] funct3 = 3'b000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
    logic [16:0] w_obs;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUOp(ALUOp), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign w_obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic string ph_name(input int ph);
        case (ph)
            PH_IDLE: return "IDLE";         PH_FETCH: return "FETCH";
            PH_DECODE: return "DECODE";     PH_MEMADR: return "MEMADR";
            PH_MEMREAD: return "MEMREAD";   PH_MEMWB: return "MEMWB";
            PH_MEMWRITE: return "MEMWRITE"; PH_EXECR: return "EXECR";
            PH_EXECI: return "EXECI";       PH_ALUWB: return "ALUWB";
            PH_BRANCH: return "BRANCH";     PH_JAL: return "JAL";
            default: return "TRAP";
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0010011: return 2'b00;
            7'b0100011:             return 2'b01;
            7'b1100011:             return 2'b10;
            7'b1101111:             return JAL_EN ? 2'b11 : 2'b00;
            default:                return 2'b00;
        endcase
    endfunction

    // Output table from the controller description, ordered like w_obs.
    function automatic logic [16:0] expect_vec(input int ph, input logic [6:0] o,
                                               input logic [2:0] f3, input logic z, input logic rdy);
        logic mreq, mw, adr, irw, pcw, rw, ill;
        logic [1:0] rs, sa, sb, aop;
        {mreq, mw, adr, irw, pcw, rw, ill} = '0;
        {rs, sa, sb, aop} = '0;
        case (ph)
            PH_FETCH:    begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            PH_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            PH_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            PH_MEMREAD:  begin mreq = 1; adr = 1; end
            PH_MEMWB:    begin rs = 2'b01; rw = 1; end
            PH_MEMWRITE: begin mreq = 1; mw = 1; adr = 1; end
            PH_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            PH_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            PH_ALUWB:    rw = 1;
            PH_BRANCH:   begin sa = 2'b10; aop = 2'b01; pcw = z ^ f3[0]; end
            PH_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            PH_TRAP:     ill = 1;
            default:     ;
        endcase
        return {mreq, mw, adr, irw, pcw, rw, rs, sa, sb, exp_imm(o), aop, ill};
    endfunction

    // Entered just after a clock edge with reset released; leaves at FETCH.
    task automatic idle_cycle();
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("IDLE", 32'(w_obs), 32'(expect_vec(PH_IDLE, op, funct3, zero, mem_ready)));
        @(posedge clk); #1;
    endtask

    // Entered at FETCH just after a clock edge. waits<0 / zfix<0 select random behaviour.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input int waits,
                             input int zfix, input bit rst_mid);
        int  q[$];
        int  ph, w, cyc;
        bit  is_wait;
        op = o;
        funct3 = f3;
        cyc = 0;
        q.push_back(PH_FETCH);
        q.push_back(PH_DECODE);
        if (o == 7'b0000011) begin q.push_back(PH_MEMADR); q.push_back(PH_MEMREAD); q.push_back(PH_MEMWB); end
        else if (o == 7'b0100011) begin q.push_back(PH_MEMADR); q.push_back(PH_MEMWRITE); end
        else if (o == 7'b0110011) begin q.push_back(PH_EXECR); q.push_back(PH_ALUWB); end
        else if (o == 7'b0010011) begin q.push_back(PH_EXECI); q.push_back(PH_ALUWB); end
        else if (o == 7'b1100011 && f3 <= 3'd1) q.push_back(PH_BRANCH);
        else if (o == 7'b1101111 && JAL_EN) begin q.push_back(PH_JAL); q.push_back(PH_ALUWB); end
        else q.push_back(PH_TRAP);

        while (q.size() > 0) begin
            ph = q.pop_front();
            if (ph == PH_TRAP) begin
                for (int k = 0; k < 10; k++) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    zero = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    check("TRAP", 32'(w_obs), 32'(expect_vec(PH_TRAP, op, funct3, zero, mem_ready)));
                    cyc++;
                    @(posedge clk); #1;
                end
                rst_n = 1'b0;
                #1;
                check("trap_rst_illegal", 32'(illegal_op), 32'd0);
                check("trap_rst_outputs", 32'(w_obs), 32'(expect_vec(PH_IDLE, op, funct3, zero, mem_ready)));
                @(posedge clk); #1;
                rst_n = 1'b1;
                idle_cycle();
                $display("instr op=%b funct3=%b trap cycles=%0d then reset", o, f3, cyc);
                return;
            end
            is_wait = (ph == PH_FETCH || ph == PH_MEMREAD || ph == PH_MEMWRITE);
            w = !is_wait ? 0 : (waits < 0) ? int'($urandom_range(0, 3)) : waits;
            for (int k = 0; k <= w; k++) begin
                mem_ready = is_wait ? (k >= w) : 1'($urandom_range(0, 1));
                zero = (zfix < 0) ? 1'($urandom_range(0, 1)) : zfix[0];
                @(negedge clk);
                check(ph_name(ph), 32'(w_obs), 32'(expect_vec(ph, op, funct3, zero, mem_ready)));
                cyc++;
                if (rst_mid && ph == PH_MEMWRITE && mem_ready == 1'b0) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("async_rst_mem_req", 32'(mem_req), 32'd0);
                    check("async_rst_memwrite", 32'(MemWrite), 32'd0);
                    check("async_rst_outputs", 32'(w_obs), 32'(expect_vec(PH_IDLE, op, funct3, zero, mem_ready)));
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    idle_cycle();
                    $display("instr op=%b funct3=%b reset in MEMWRITE after %0d cycles", o, f3, cyc);
                    return;
                end
                @(posedge clk); #1;
            end
        end
        $display("instr op=%b funct3=%b cycles=%0d", o, f3, cyc);
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [6:0] o;
        logic [2:0] f3;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(w_obs), 32'(expect_vec(PH_IDLE, op, funct3, zero, mem_ready)));
        rst_n = 1'b1;
        idle_cycle();

        run_instr(7'b0010011, 3'b000, 0, -1, 1'b0);   // addi, no waits
        run_instr(7'b0000011, 3'b010, 2, -1, 1'b0);   // lw, two wait cycles
        run_instr(7'b1100011, 3'b000, 0, 1, 1'b0);    // beq, zero=1 -> taken
        run_instr(7'b1100011, 3'b001, 0, 1, 1'b0);    // bne, zero=1 -> not taken
        run_instr(7'b0110011, 3'b000, 1, -1, 1'b0);   // R-type
        run_instr(7'b0100011, 3'b010, 2, -1, 1'b1);   // sw, reset during wait
        run_instr(7'b1101111, 3'b000, 0, -1, 1'b0);   // jal
        run_instr(7'b1111111, 3'b000, 0, -1, 1'b0);   // illegal opcode
        run_instr(7'b1100011, 3'b100, 0, -1, 1'b0);   // unsupported branch funct3

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) o = 7'($urandom_range(0, 127));
            else o = ops[$urandom_range(0, 5)];
            f3 = (o == 7'b1100011) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            run_instr(o, f3, -1, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 op  in  7  opcode of the instruction currently held in the instruction register.
REQ-004 funct3  in  3  funct3 field of the held instruction; used only for branches.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completion strobe for the current request.
REQ-007 mem_req  out  1  memory access request; held high until mem_ready.
REQ-008 MemWrite  out  1  store strobe, qualifies mem_req.
REQ-009 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-010 IRWrite  out  1  instruction register load enable.
REQ-011 PCWrite  out  1  PC load enable.
REQ-012 RegWrite  out  1  register file write enable.
REQ-013 ResultSrc  out  2  result select: 00 = ALU register, 01 = memory data, 10 = ALU result.
REQ-014 ALUSrcA / ALUSrcB  out  2 each  ALU operand selects. A: 00 = PC, 01 = old PC, 10 = rs1. B: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-015 ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-016 ALUOp  out  2  00 = add, 01 = subtract/compare, 10 = decode by funct3/funct7.
REQ-017 illegal_op  out  1  sticky flag: an unsupported opcode or branch funct3 was decoded.

Function
REQ-018 States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL (macro-gated), TRAP.
REQ-019 Every output not listed for a state SHALL be 0 in that state.
REQ-020 IDLE: all outputs 0; unconditionally go to FETCH next cycle.
REQ-021 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=1 only in the mem_ready cycle. Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
REQ-022 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 with funct3 000/001 -> BRANCH
- 1101111 -> JAL (macro on)
- all others -> TRAP
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op=0000011, else to MEMWRITE.
REQ-024 MEMREAD: mem_req=1, AdrSrc=1. Wait for mem_ready, then go to MEMWB.
REQ-025 MEMWB: ResultSrc=01, RegWrite=1; then FETCH.
REQ-026 MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Wait for mem_ready, then FETCH.
REQ-027 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; then ALUWB.
REQ-028 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; then ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1; then FETCH.
REQ-030 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = zero XOR funct3[0] (beq/bne). Then FETCH.
REQ-031 TRAP: illegal_op=1, all other outputs 0; remain in TRAP until reset.
REQ-032 ImmSrc SHALL be combinational from op in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11 (macro on), otherwise 00.
REQ-033 mem_ready SHALL be ignored in states that do not assert mem_req.
REQ-034 Cycles per instruction with zero wait states: R/I-type 4, load 5, store 4, branch 3, jal 4. Each extra mem_ready=0 cycle adds 1.

Reset
REQ-035 rst_n low SHALL force state to IDLE asynchronously, including mid-instruction or mid-wait, and clear illegal_op.
REQ-036 While rst_n is low and in IDLE, all outputs SHALL be 0 except the combinational ImmSrc.

Configuration
REQ-037 Macro RV_JAL_EN, when defined: enables the JAL state (ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB) and ImmSrc=11 for op 1101111.
REQ-038 Without RV_JAL_EN: op 1101111 decodes to TRAP, and ImmSrc=00 for that opcode.

Structure
REQ-039 Shared package ctrl_pkg SHALL hold the state enum, opcode localparams, and the ALUOp, ResultSrc, ALUSrcA and ALUSrcB encodings.
REQ-040 Sub-module imm_src_decoder SHALL implement REQ-032; all state logic lives in multicycle_controller.

Verification
REQ-041 addi (op 0010011), mem_ready=1 always -> states FETCH, DECODE, EXECI, ALUWB; RegWrite high only in cycle 4.
REQ-042 lw with mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles with mem_req=1, AdrSrc=1; MEMWB RegWrite=1, ResultSrc=01.
REQ-043 beq, zero=1 -> PCWrite=1 in BRANCH. bne (funct3 001), zero=1 -> PCWrite=0.
REQ-044 op 1111111 -> TRAP, illegal_op=1 held for 10 cycles. Then rst_n pulse -> IDLE, illegal_op=0, FETCH the next cycle.
REQ-045 rst_n asserted in MEMWRITE mid-wait -> MemWrite and mem_req fall to 0 immediately, without waiting for a clock edge.
REQ-046 jal with and without RV_JAL_EN -> JAL then ALUWB with ImmSrc=11, versus TRAP with ImmSrc=00.
